// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a DEPTH-entry prefetch FIFO.
// Keeps at most one request in flight to a variable-latency instruction
// memory and buffers returned words for decode. A redirect flushes the FIFO
// and makes sure any outstanding response is thrown away when it arrives.
module ifu_prefetch #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 'h80000000,
   parameter int              DEPTH    = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic                   o_imem_req_valid,
   input  logic                   i_imem_req_ready,
   output logic [XLEN-1:0]        o_imem_req_addr,
   input  logic                   i_imem_rsp_valid,
   input  logic [31:0]            i_imem_rsp_data,
   input  logic                   i_redirect_en,
   input  logic [XLEN-1:0]        i_redirect_pc,
   output logic                   o_ifu_valid,
   input  logic                   i_ifu_ready,
   output logic [XLEN-1:0]        o_ifu_pc,
   output logic [31:0]            o_ifu_instr,
   output logic [XLEN-1:0]        o_ifu_snxt_pc,
   output logic [$clog2(DEPTH):0] o_ifu_count
);

   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP    = 4;
   localparam logic [XLEN-1:0] PC_LOW     = 3;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~PC_LOW;
   localparam logic [31:0]     NOP_INSTR  = 32'h00000013;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_DROP
   } StateT;

   StateT           r_state;
   StateT           w_nextState;
   logic [XLEN-1:0] r_fetchPc;
   logic [XLEN-1:0] r_reqPc;
   logic [XLEN-1:0] r_fifoPc    [DEPTH];
   logic [31:0]     r_fifoInstr [DEPTH];
   logic [AW-1:0]   r_rdPtr;
   logic [AW-1:0]   r_wrPtr;
   logic [AW:0]     r_count;

   logic            w_reqFire;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_redirectAligned;

   assign w_redirectAligned = i_redirect_pc & ALIGN_MASK;
   assign w_reqFire         = o_imem_req_valid & i_imem_req_ready;
   assign w_push            = (r_state == S_WAIT) & i_imem_rsp_valid & ~i_redirect_en;
   assign w_pop             = o_ifu_valid & i_ifu_ready & ~i_redirect_en;

   assign o_imem_req_addr = r_fetchPc;
   assign o_ifu_valid     = (r_count != '0);
   assign o_ifu_pc        = r_fifoPc[r_rdPtr];
   assign o_ifu_instr     = r_fifoInstr[r_rdPtr];
   assign o_ifu_snxt_pc   = o_ifu_pc + PC_STEP;
   assign o_ifu_count     = r_count;

   // Fetch state register; reset lands in ISSUE so the first request goes out immediately.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_ISSUE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and request-valid logic; a redirect turns any outstanding request into one to drop.
   always_comb begin
      w_nextState      = r_state;
      o_imem_req_valid = 1'b0;
      case (r_state)
         S_ISSUE: begin
            o_imem_req_valid = (r_count < FULL_COUNT);
            if (w_reqFire) begin
               w_nextState = i_redirect_en ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_imem_rsp_valid) begin
               w_nextState = S_ISSUE;
            end else if (i_redirect_en) begin
               w_nextState = S_DROP;
            end
         end
         S_DROP: begin
            if (i_imem_rsp_valid) begin
               w_nextState = S_ISSUE;
            end
         end
         default: begin
            w_nextState = S_ISSUE;
         end
      endcase
   end

   // Fetch address and in-flight PC; the redirect target overrides the normal +4 advance.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetchPc <= RESET_PC & ALIGN_MASK;
         r_reqPc   <= '0;
      end else begin
         if (w_reqFire) begin
            r_reqPc <= r_fetchPc;
         end
         if (i_redirect_en) begin
            r_fetchPc <= w_redirectAligned;
         end else if (w_reqFire) begin
            r_fetchPc <= r_fetchPc + PC_STEP;
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer regardless of push or pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (i_redirect_en) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; entries start as a NOP at pc 0 so the head is never X after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_fifoPc[i]    <= '0;
            r_fifoInstr[i] <= NOP_INSTR;
         end
      end else if (w_push) begin
         r_fifoPc[r_wrPtr]    <= r_reqPc;
         r_fifoInstr[r_wrPtr] <= i_imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: self-checking bench for ifu_prefetch with a variable
// latency memory model and a scoreboard of expected decode-side instructions.
module tb_ifu_prefetch;

   localparam logic [63:0] RESET_PC = 64'h80000000;
   localparam int          DEPTH    = 4;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ExpT;

   typedef struct {
      logic [63:0] pcIn;
      logic [63:0] expFirst;
      logic [63:0] expSecond;
   } RedirVecT;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic [63:0] reqAddr;
   logic        rspValid;
   logic [31:0] rspData;
   logic        redirectEn;
   logic [63:0] redirectPc;
   logic        ifuValid;
   logic        ifuReady;
   logic [63:0] ifuPc;
   logic [31:0] ifuInstr;
   logic [63:0] ifuSnxtPc;
   logic [2:0]  ifuCount;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   logic        rstReq = 1'b1;
   logic        memReady = 1'b1;
   int          memLatency = 1;
   logic        redirReq = 1'b0;
   logic [63:0] redirPcReq = '0;
   logic        ifuReadyReq = 1'b1;

   logic        memBusy = 1'b0;
   logic        memStale = 1'b0;
   int          memCountdown = 0;
   logic [63:0] memAddr = '0;
   logic [63:0] expAddr = RESET_PC;

   logic        sReqValid, sIfuValid, sRspValid, sFire;
   logic [63:0] sReqAddr;
   logic [2:0]  sIfuCount;

   ExpT         expQ[$];
   logic [63:0] fireAddrQ[$];
   int          fireCycQ[$];
   logic [63:0] popPcQ[$];
   int          popCycQ[$];

   RedirVecT    vecs[5];

   ifu_prefetch #(
      .XLEN(64),
      .RESET_PC(RESET_PC),
      .DEPTH(DEPTH)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .o_imem_req_valid(reqValid),
      .i_imem_req_ready(reqReady),
      .o_imem_req_addr(reqAddr),
      .i_imem_rsp_valid(rspValid),
      .i_imem_rsp_data(rspData),
      .i_redirect_en(redirectEn),
      .i_redirect_pc(redirectPc),
      .o_ifu_valid(ifuValid),
      .i_ifu_ready(ifuReady),
      .o_ifu_pc(ifuPc),
      .o_ifu_instr(ifuInstr),
      .o_ifu_snxt_pc(ifuSnxtPc),
      .o_ifu_count(ifuCount)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation did not finish, cycle %0d", cycleCount);
      $fatal(1, "[TB] global timeout");
   end

   function automatic logic [31:0] instrOf(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A000013;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, sample just after,
   // then advance the memory model and scoreboard to match the coming rising edge.
   task automatic applyStimulus();
      ExpT head;
      @(negedge clk);
      rst = rstReq;
      if (memBusy && memCountdown == 0) begin
         rspValid = 1'b1;
         rspData  = instrOf(memAddr);
      end else begin
         rspValid = 1'b0;
         rspData  = '0;
      end
      reqReady   = memReady && !rstReq;
      redirectEn = redirReq;
      redirectPc = redirPcReq;
      ifuReady   = ifuReadyReq;
      #1;
      cycleCount++;
      sReqValid = reqValid;
      sReqAddr  = reqAddr;
      sIfuValid = ifuValid;
      sIfuCount = ifuCount;
      sRspValid = rspValid;
      sFire     = reqValid && reqReady;
      if (rst) begin
         expQ.delete();
         if (memBusy) memStale = 1'b1;
         if (rspValid) memBusy = 1'b0;
         else if (memBusy) memCountdown--;
         expAddr = RESET_PC;
      end else begin
         checkOutput("ifuCount", 64'(ifuCount), 64'(expQ.size()));
         checkOutput("ifuValid", 64'(ifuValid), 64'(expQ.size() != 0));
         if (sFire) checkOutput("issueWhenFull", 64'(expQ.size() < DEPTH), 64'd1);
         if (ifuValid && ifuReady && !redirectEn && expQ.size() != 0) begin
            head = expQ.pop_front();
            checkOutput("ifuPc", ifuPc, head.pc);
            checkOutput("ifuInstr", 64'(ifuInstr), 64'(head.instr));
            checkOutput("ifuSnxtPc", ifuSnxtPc, head.pc + 64'd4);
            popPcQ.push_back(ifuPc);
            popCycQ.push_back(cycleCount);
         end
         if (redirectEn) begin
            expQ.delete();
            if (memBusy) memStale = 1'b1;
         end
         if (rspValid) begin
            memBusy = 1'b0;
            if (!memStale) expQ.push_back('{memAddr, instrOf(memAddr)});
         end else if (memBusy) begin
            memCountdown--;
         end
         if (sFire) begin
            checkOutput("oneInFlight", 64'(memBusy), 64'd0);
            checkOutput("reqAddr", reqAddr, expAddr);
            memBusy      = 1'b1;
            memCountdown = memLatency - 1;
            memAddr      = reqAddr;
            memStale     = redirectEn;
            fireAddrQ.push_back(reqAddr);
            fireCycQ.push_back(cycleCount);
         end
         if (redirectEn) expAddr = redirectPc & ~64'd3;
         else if (sFire) expAddr = expAddr + 64'd4;
      end
   endtask

   task automatic doReset();
      rstReq   = 1'b1;
      redirReq = 1'b0;
      applyStimulus();
      for (int i = 0; i < 10 && memBusy; i++) applyStimulus();
      applyStimulus();
      rstReq = 1'b0;
      fireAddrQ.delete();
      fireCycQ.delete();
      popPcQ.delete();
      popCycQ.delete();
   endtask

   task automatic waitFires(input string name, input int n, input int bound);
      for (int i = 0; i < bound && fireAddrQ.size() < n; i++) applyStimulus();
      checkOutput({name, "FireTimeout"}, 64'(fireAddrQ.size() >= n), 64'd1);
   endtask

   task automatic waitPops(input string name, input int n, input int bound);
      for (int i = 0; i < bound && popPcQ.size() < n; i++) applyStimulus();
      checkOutput({name, "PopTimeout"}, 64'(popPcQ.size() >= n), 64'd1);
   endtask

   // Main test sequence: vector table for redirect alignment and wrap, then hand-written corner cases.
   initial begin
      vecs[0] = '{64'h0000000080001002, 64'h0000000080001000, 64'h0000000080001004};
      vecs[1] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000000};
      vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000000};
      vecs[3] = '{64'h0000000000000003, 64'h0000000000000000, 64'h0000000000000004};
      vecs[4] = '{64'h0000000012345679, 64'h0000000012345678, 64'h000000001234567C};

      rst = 1'b1; reqReady = 1'b0; rspValid = 1'b0; rspData = '0;
      redirectEn = 1'b0; redirectPc = '0; ifuReady = 1'b1;

      $display("[TB] reset release and streaming fetch");
      memLatency = 1; memReady = 1'b1; ifuReadyReq = 1'b1;
      doReset();
      applyStimulus();
      checkOutput("rstReqValid", 64'(sReqValid), 64'd1);
      checkOutput("rstReqAddr", sReqAddr, RESET_PC);
      checkOutput("rstIfuValid", 64'(sIfuValid), 64'd0);
      checkOutput("rstIfuCount", 64'(sIfuCount), 64'd0);
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("seqPc0", popPcQ[0], 64'h80000000);
      checkOutput("seqPc1", popPcQ[1], 64'h80000004);
      checkOutput("seqPc2", popPcQ[2], 64'h80000008);
      checkOutput("latValid", 64'(popCycQ[0] - fireCycQ[0]), 64'd2);
      checkOutput("latNextReq", 64'(fireCycQ[1] - fireCycQ[0]), 64'd2);

      $display("[TB] decode stall fills the buffer");
      doReset();
      ifuReadyReq = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus();
      checkOutput("stallFires", 64'(fireAddrQ.size()), 64'd4);
      checkOutput("stallReqValid", 64'(sReqValid), 64'd0);
      checkOutput("stallCount", 64'(sIfuCount), 64'd4);
      ifuReadyReq = 1'b1;
      waitPops("stall", 4, 20);
      for (int i = 0; i < 4; i++) checkOutput("stallOrder", popPcQ[i], RESET_PC + 64'(4 * i));
      waitFires("stallResume", 5, 10);
      checkOutput("resumeAfterPop", 64'(fireCycQ[4]), 64'(popCycQ[0] + 1));

      $display("[TB] redirect while waiting, slow response");
      memLatency = 3;
      doReset();
      waitFires("redirWait", 1, 5);
      redirReq = 1'b1; redirPcReq = 64'h80001002;
      applyStimulus();
      checkOutput("redirWaitNoRsp", 64'(sRspValid), 64'd0);
      redirReq = 1'b0;
      applyStimulus();
      checkOutput("redirFlushValid", 64'(sIfuValid), 64'd0);
      checkOutput("redirFlushCount", 64'(sIfuCount), 64'd0);
      checkOutput("dropNoReq", 64'(sReqValid), 64'd0);
      applyStimulus();
      checkOutput("lateRsp", 64'(sRspValid), 64'd1);
      waitFires("redirWait", 2, 10);
      checkOutput("redirReqAddr", fireAddrQ[1], 64'h80001000);
      waitPops("redirWait", 1, 20);
      checkOutput("redirPopPc", popPcQ[0], 64'h80001000);

      $display("[TB] redirect together with a response");
      memLatency = 2;
      doReset();
      waitFires("redirRsp", 1, 5);
      applyStimulus();
      redirReq = 1'b1; redirPcReq = 64'h80002000;
      applyStimulus();
      checkOutput("redirRspCoincide", 64'(sRspValid), 64'd1);
      redirReq = 1'b0;
      applyStimulus();
      checkOutput("redirRspValid", 64'(sIfuValid), 64'd0);
      checkOutput("redirRspReqAddr", sReqAddr, 64'h80002000);
      waitPops("redirRsp", 1, 20);
      checkOutput("redirRspPopPc", popPcQ[0], 64'h80002000);

      $display("[TB] redirect together with a request handshake");
      memLatency = 1;
      doReset();
      memReady = 1'b0;
      applyStimulus();
      applyStimulus();
      memReady = 1'b1; redirReq = 1'b1; redirPcReq = 64'h80003000;
      applyStimulus();
      checkOutput("redirFireCoincide", 64'(sFire), 64'd1);
      redirReq = 1'b0;
      applyStimulus();
      checkOutput("redirFireValid", 64'(sIfuValid), 64'd0);
      checkOutput("redirFireDrop", 64'(sReqValid), 64'd0);
      waitPops("redirFire", 1, 20);
      checkOutput("redirFirePopPc", popPcQ[0], 64'h80003000);

      $display("[TB] push and pop in the same cycle");
      doReset();
      ifuReadyReq = 1'b0;
      for (int i = 0; i < 30 && !(sFire && sIfuCount == 3'd2); i++) applyStimulus();
      checkOutput("pushPopSetup", 64'(sFire && sIfuCount == 3'd2), 64'd1);
      ifuReadyReq = 1'b1;
      applyStimulus();
      checkOutput("pushPopRsp", 64'(sRspValid && sIfuValid), 64'd1);
      ifuReadyReq = 1'b0;
      applyStimulus();
      checkOutput("pushPopCount", 64'(sIfuCount), 64'd2);
      ifuReadyReq = 1'b1;
      waitPops("pushPop", 3, 20);
      for (int i = 0; i < 3; i++) checkOutput("pushPopOrder", popPcQ[i], RESET_PC + 64'(4 * i));

      $display("[TB] redirect target table");
      for (int v = 0; v < 5; v++) begin
         doReset();
         memReady = 1'b0; redirReq = 1'b1; redirPcReq = vecs[v].pcIn;
         applyStimulus();
         redirReq = 1'b0; memReady = 1'b1;
         waitFires("vec", 2, 10);
         checkOutput("vecFirstAddr", fireAddrQ[0], vecs[v].expFirst);
         checkOutput("vecSecondAddr", fireAddrQ[1], vecs[v].expSecond);
         waitPops("vec", 1, 10);
         checkOutput("vecPopPc", popPcQ[0], vecs[v].expFirst);
      end

      $display("[TB] reset with a request in flight");
      doReset();
      memReady = 1'b0; redirReq = 1'b1; redirPcReq = 64'h80005000;
      applyStimulus();
      redirReq = 1'b0; memLatency = 3; memReady = 1'b1;
      waitFires("midRst", 1, 5);
      checkOutput("midRstFirstAddr", fireAddrQ[0], 64'h80005000);
      memReady = 1'b0; rstReq = 1'b1;
      applyStimulus();
      rstReq = 1'b0;
      applyStimulus();
      checkOutput("midRstReqValid", 64'(sReqValid), 64'd1);
      checkOutput("midRstReqAddr", sReqAddr, RESET_PC);
      checkOutput("midRstIfuValid", 64'(sIfuValid), 64'd0);
      for (int i = 0; i < 10 && memBusy; i++) applyStimulus();
      checkOutput("midRstDrained", 64'(memBusy), 64'd0);
      memReady = 1'b1;
      waitFires("midRst", 2, 10);
      checkOutput("midRstRestartAddr", fireAddrQ[1], RESET_PC);
      waitPops("midRst", 1, 20);
      checkOutput("midRstPopPc", popPcQ[0], RESET_PC);

      for (int i = 0; i < 5; i++) applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with a prefetch buffer. It issues fetch requests to a variable-latency instruction memory and keeps at most one request in flight. Returned instructions go into a DEPTH-entry FIFO, which is presented to decode through a valid/ready handshake. Control-flow redirects from execute flush the FIFO and discard any stale in-flight response. The block sits between the instruction memory port and the IF/ID boundary.

## Interface
Parameters:
- XLEN, 64, address/PC width
- RESET_PC, 64'h80000000, first fetch address after reset
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, always 4-byte aligned
- imem_rsp_valid  input  1  response valid; always accepted, no back-pressure
- imem_rsp_data  input  32  instruction word
- redirect_en  input  1  jump/branch taken; flush and refetch
- redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- ifu_valid  output  1  FIFO head valid
- ifu_ready  input  1  decode accepts head (0 = load-hazard stall)
- ifu_pc  output  XLEN  PC of head instruction
- ifu_instr  output  32  head instruction
- ifu_snxt_pc  output  XLEN  ifu_pc + 4, modulo 2^XLEN
- ifu_count  output  log2(DEPTH)+1  FIFO occupancy

## Operation
- Registers:
  - fetch_pc (XLEN)
  - FIFO of {pc, instr} with rd/wr pointers and count
  - req_pc (PC of the in-flight request)
  - state
- FSM:
  - ISSUE:
    - imem_req_valid = (count < DEPTH); no dependence on redirect_en.
    - On handshake: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4, go to WAIT.
  - WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_data}, go to ISSUE. The push cannot overflow, because issue requires count < DEPTH and only responses push.
  - DROP: on imem_rsp_valid, discard the response and go to ISSUE.
- imem_rsp_valid is ignored in ISSUE.
- Memory must not respond in the same cycle as request acceptance; minimum latency is 1 cycle.
- Pop: when ifu_valid && ifu_ready, the read pointer advances. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, overrides push/pop this cycle):
  - FIFO cleared (count <= 0, pointers <= 0); fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - ISSUE with handshake this cycle → DROP (that request is stale).
  - ISSUE without handshake → stay ISSUE.
  - WAIT with imem_rsp_valid this cycle → response discarded, go to ISSUE.
  - WAIT without response → DROP.
  - DROP with imem_rsp_valid → ISSUE; without → stay DROP.
- Outputs come straight from the FIFO head. There is no bypass: a response is visible on ifu_* at the earliest the cycle after it arrives.
- Output fields are don't-care when ifu_valid=0, but they must not be X after reset: the FIFO storage resets to pc=0, instr=32'h13.
- Arithmetic: all PC increments wrap modulo 2^XLEN (e.g. 0xFFFF_FFFF_FFFF_FFFC + 4 → 0).

## Timing
- Reset values:
  - state=ISSUE, fetch_pc=RESET_PC, count=0
  - ifu_valid=0, ifu_count=0
  - imem_req_valid=1 (combinational from state/count) from the first cycle rst is low; imem_req_addr=RESET_PC
- rst asserted mid-operation returns to the reset state next cycle. A late response from a pre-reset request arrives in ISSUE and is ignored.
- Latency, with a 1-cycle memory and always-ready decode:
  - request accepted cycle N, response N+1, ifu_valid N+2
  - next request N+2
  - throughput 1 instruction / 2 cycles
- Redirect at cycle N: ifu_valid=0 at N+1; imem_req_addr=redirect_pc at N+1 unless in DROP.
- Full: count==DEPTH holds imem_req_valid low until a pop. The request goes out the cycle after the pop.

## Test plan
- Reset release, 1-cycle memory, ifu_ready=1:
  - first request addr 0x80000000
  - ifu_pc sequence 0x80000000, 0x80000004, 0x80000008
  - ifu_snxt_pc = ifu_pc + 4
- ifu_ready=0 for 20 cycles, DEPTH=4:
  - exactly 4 requests issued, then imem_req_valid=0, ifu_count=4
  - after release, instructions come out in order and fetching resumes
- Redirect to 0x80001002 while in WAIT, response 3 cycles later:
  - response dropped, FIFO empty
  - next request addr 0x80001000; ifu_pc of the next instruction is 0x80001000
- Redirect in the same cycle as imem_rsp_valid in WAIT, and in the same cycle as a request handshake in ISSUE: in both cases no stale instruction ever reaches ifu_valid.
- Push+pop in the same cycle with count=2: count stays 2, ordering preserved.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC: second request addr wraps to 0x0.
- rst pulsed with a request in flight: the late response is ignored and fetch restarts at RESET_PC.
